// File: rtl/iob_rom_arbiter_pkg.sv
// Shared constants for the ROM read arbiter: requester-count bounds, response latencies, pointer width helper.
// IOB_ROM_ARB_OUTREG_EN selects the two-cycle response latency.
package iob_rom_arbiter_pkg;

  localparam int N_REQ_MIN  = 2;
  localparam int N_REQ_MAX  = 8;
  localparam int RESP_LAT_1 = 1;
  localparam int RESP_LAT_2 = 2;

`ifdef IOB_ROM_ARB_OUTREG_EN
  localparam int RESP_LAT = RESP_LAT_2;
`else
  localparam int RESP_LAT = RESP_LAT_1;
`endif

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Round-robin priority search, purely combinational: one-hot grant to the first
// active request found starting at (ptr_i+1) mod N and wrapping.
module iob_rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  int sh;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    gnt_o = '0;
    sh    = 0;
    for (int k = N; k >= 1; k--) begin
      sh = (int'(ptr_i) + k) % N;
      if ((req_i & (ONE << sh)) != '0) begin
        gnt_o = ONE << sh;
      end
    end
  end

endmodule

// File: rtl/iob_rom_arbiter.sv
// Round-robin arbiter sharing one external ROM read port among N_REQ requesters; response 1 cycle after
// acceptance (2 with IOB_ROM_ARB_OUTREG_EN), one accept per cycle, no response backpressure.
module iob_rom_arbiter
  import iob_rom_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    rom_r_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_r_data
);

  localparam int PTR_W = ptr_w(N_REQ);

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
    $error("iob_rom_arbiter: N_REQ out of range");
  end

  logic [PTR_W-1:0] last_grant_q, last_grant_d;
  logic [N_REQ-1:0] arb_gnt;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] resp_vld_q;

  iob_rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (last_grant_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    grant        = rst ? '0 : arb_gnt;
    req_ready    = grant;
    rom_r_en     = |grant;
    rom_addr     = '0;
    last_grant_d = last_grant_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        rom_addr     = req_addr[i*ADDR_W +: ADDR_W];
        last_grant_d = PTR_W'(i);
      end
    end
  end

  // Reset clears the in-flight strobe, so a request accepted just before reset never responds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PTR_W'(N_REQ - 1);
      resp_vld_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      resp_vld_q   <= grant;
    end
  end

`ifdef IOB_ROM_ARB_OUTREG_EN
  logic [N_REQ-1:0]  resp_vld2_q;
  logic [DATA_W-1:0] resp_dat2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_vld2_q <= '0;
      resp_dat2_q <= '0;
    end else begin
      resp_vld2_q <= resp_vld_q;
      resp_dat2_q <= (|resp_vld_q) ? rom_r_data : '0;
    end
  end

  assign resp_valid = rst ? '0 : resp_vld2_q;
  assign resp_data  = rst ? '0 : resp_dat2_q;
`else
  assign resp_valid = rst ? '0 : resp_vld_q;
  assign resp_data  = (|resp_valid) ? rom_r_data : '0;
`endif

endmodule

// File: doc/iob_rom_arbiter.md
IOB_ROM_ARBITER -- requirements
Module: iob_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, ROM word width.
REQ-003 SHALL have parameter ADDR_W, default 10, ROM address width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester read request.
REQ-007 SHALL have port req_addr  input  N_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot grant; request i accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port resp_valid  output  N_REQ  one-hot, one-cycle response strobe.
REQ-010 SHALL have port resp_data  output  DATA_W  shared read data, valid when any resp_valid bit is high.
REQ-011 SHALL have port rom_r_en  output  1  ROM read enable.
REQ-012 SHALL have port rom_addr  output  ADDR_W  ROM address.
REQ-013 SHALL have port rom_r_data  input  DATA_W  ROM data, one-cycle registered read latency.

Function
REQ-014 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid and the priority pointer.
REQ-015 SHALL use round-robin priority: search starts at (last_grant+1) mod N_REQ, wrapping; last_grant updates only on an accepted request.
REQ-016 SHALL drive rom_r_en = 1 and rom_addr = granted requester's address in the acceptance cycle; otherwise rom_r_en = 0 and rom_addr = 0.
REQ-017 SHALL assert resp_valid[i] exactly one cycle after the acceptance of requester i; resp_data = rom_r_data in that cycle.
REQ-018 SHALL sustain one accepted request per cycle; back-to-back grants to different requesters produce back-to-back responses in grant order.
REQ-019 SHALL let a sole active requester be granted every cycle (no forced idle).
REQ-020 SHALL have no response backpressure; requesters always take resp_valid.
REQ-021 SHALL drive resp_data = 0 when no resp_valid bit is high.
REQ-022 SHALL keep last_grant unchanged when req_valid is all zero.

Reset
REQ-023 SHALL, while rst is high, force req_ready = 0, resp_valid = 0, resp_data = 0, rom_r_en = 0, rom_addr = 0 and last_grant = N_REQ-1, so that requester 0 has first priority after release.
REQ-024 SHALL discard a request accepted in the cycle before rst asserts; no response is issued for it after release.

Configuration
REQ-025 SHALL support macro IOB_ROM_ARB_OUTREG_EN: when defined, resp_data and resp_valid are registered once more, giving a latency of 2 cycles from acceptance; throughput remains one per cycle.
REQ-026 SHALL, without IOB_ROM_ARB_OUTREG_EN, use a latency of 1 cycle as in REQ-017.

Structure
REQ-027 SHALL place the N_REQ bounds and latency constants (RESP_LAT_1 = 1, RESP_LAT_2 = 2) in the shared package iob_rom_arbiter_pkg.
REQ-028 SHALL implement the priority search in one sub-module, iob_rr_arbiter (inputs: request vector and pointer; output: one-hot grant).
REQ-029 SHALL keep the ROM external; the block connects only to the ROM ports.

Verification
REQ-030 SHALL cover reset release: with N_REQ=2 and both valid in the first cycle -> req_ready=01, rom_addr=req0 address, and resp_valid=01 one cycle later.
REQ-031 SHALL cover fairness: both requesters held valid for 6 cycles (addr0=0x005, addr1=0x3FF) -> grants alternate 0,1,0,1,0,1 and resp_data matches ROM[0x005] and ROM[0x3FF] alternately.
REQ-032 SHALL cover a sole requester: only req1 valid for 4 cycles at addresses 1,2,3,4 -> 4 consecutive grants and resp_valid=10 on 4 consecutive cycles with data ROM[1..4].
REQ-033 SHALL cover wrap-around: N_REQ=4, last grant 3, req_valid=1001 -> requester 0 granted next, then requester 3.
REQ-034 SHALL cover mid-operation reset: rst asserted the cycle after acceptance -> resp_valid stays 0 and the next grant goes to requester 0.
REQ-035 SHALL cover IOB_ROM_ARB_OUTREG_EN defined: the scenario of REQ-030 -> resp_valid appears 2 cycles after acceptance with identical data.
